// File: rtl/id_stage.sv
// id_stage - instruction decode stage of the five-stage 32-bit pipeline.
//
// Takes the IF/ID pair (Next_Address, Instruction). It reads the register
// file, with same-cycle write-back bypass, and decodes the control word.
// Branches and jumps are resolved here. It detects load-use and
// branch-operand hazards and registers everything into ID/EX.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   Next_Address, Instruction IF/ID pair
//   wb_we, wb_addr, wb_data   register-file write port (write-back stage)
//   exmem_regwrite, exmem_rd  destination of the instruction in MEM
//   PCWrite, hzdetect         stall handshake back to IF
//   PCSrc, Branch_Address     redirect to IF (taken branch/jump)
//   flush                     clear IF/ID on the next edge
//   ctrl_out .. pc4_out       ID/EX pipeline register
//   ctrl_out bit map:
//     [0] reg_write  [1] mem_to_reg  [2] mem_read  [3] mem_write
//     [4] alu_src    [5] reg_dst     [7:6] alu_op
module id_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Next_Address,
    input  logic [31:0]     Instruction,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    output logic            PCWrite,
    output logic            hzdetect,
    output logic            PCSrc,
    output logic [XLEN-1:0] Branch_Address,
    output logic            flush,
    output logic [7:0]      ctrl_out,
    output logic [XLEN-1:0] rs_data_out,
    output logic [XLEN-1:0] rt_data_out,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rs_out,
    output logic [4:0]      rt_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] pc4_out
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign imm16  = Instruction[15:0];

    // ---------------- decode ----------------
    logic [7:0] ctrl;
    logic       is_r, is_sw, is_beq, is_bne, is_j, is_br;

    always_comb begin
        ctrl = 8'h00;
        unique case (opcode)
            OP_R:    ctrl = 8'b10_1_0_0_0_0_1;
            OP_LW:   ctrl = 8'b00_0_1_0_1_1_1;
            OP_SW:   ctrl = 8'b00_0_1_1_0_0_0;
            OP_ADDI: ctrl = 8'b00_0_1_0_0_0_1;
            default: ctrl = 8'h00;   // branches, jump and unknown opcodes
        endcase
    end

    assign is_r   = (opcode == OP_R);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);
    assign is_br  = is_beq | is_bne;

    // ---------------- register file ----------------
    // Entry 0 is never written, so it stays zero. The read path also forces
    // r0 to zero explicitly.
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs_val, rt_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // A write landing this cycle is visible to this cycle's reader. This
    // covers the WB->ID distance without a stall.
    assign rs_val = (rs == 5'd0) ? '0 :
                    (wb_we && wb_addr == rs) ? wb_data : regs[rs];
    assign rt_val = (rt == 5'd0) ? '0 :
                    (wb_we && wb_addr == rt) ? wb_data : regs[rt];

    // ---------------- hazard detection ----------------
    logic       uses_rt, haz_load, haz_br, stall;
    logic [4:0] idex_dst;

    assign uses_rt  = is_r | is_sw | is_br;
    assign idex_dst = ctrl_out[5] ? rd_out : rt_out;

    // A load in EX cannot forward its result to the next instruction.
    assign haz_load = ctrl_out[2] && (rt_out != 5'd0) &&
                      ((rt_out == rs) || (uses_rt && rt_out == rt));

    // Branches compare in ID. Any producer still in EX or MEM is too late.
    assign haz_br = is_br &&
        ((ctrl_out[0] && idex_dst != 5'd0 &&
          (idex_dst == rs || idex_dst == rt)) ||
         (exmem_regwrite && exmem_rd != 5'd0 &&
          (exmem_rd == rs || exmem_rd == rt)));

    assign stall    = haz_load | haz_br;
    assign PCWrite  = ~stall;
    assign hzdetect = stall;

    // ---------------- branch unit ----------------
    logic            taken;
    logic [XLEN-1:0] br_target, j_target;

    assign br_target = Next_Address + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    assign j_target  = {Next_Address[XLEN-1:28], Instruction[25:0], 2'b00};

    assign taken = (is_beq && rs_val == rt_val) ||
                   (is_bne && rs_val != rt_val) || is_j;

    assign Branch_Address = is_j ? j_target : br_target;
    // A stalled branch is re-resolved when it re-presents next cycle.
    assign PCSrc = taken & ~stall;
    assign flush = taken & ~stall;

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_out    <= '0;
            rs_data_out <= '0;
            rt_data_out <= '0;
            imm_out     <= '0;
            rs_out      <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            pc4_out     <= '0;
        end else begin
            ctrl_out    <= stall ? 8'h00 : ctrl;   // bubble on stall
            rs_data_out <= rs_val;
            rt_data_out <= rt_val;
            imm_out     <= {{(XLEN-16){imm16[15]}}, imm16};
            rs_out      <= rs;
            rt_out      <= rt;
            rd_out      <= rd;
            pc4_out     <= Next_Address;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Next_Address, Instruction, wb_data;
    logic        wb_we, exmem_regwrite;
    logic [4:0]  wb_addr, exmem_rd;
    logic        PCWrite, hzdetect, PCSrc, flush;
    logic [31:0] Branch_Address, rs_data_out, rt_data_out, imm_out, pc4_out;
    logic [7:0]  ctrl_out;
    logic [4:0]  rs_out, rt_out, rd_out;

    int n_chk  = 0;
    int n_fail = 0;

    id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .Next_Address(Next_Address), .Instruction(Instruction),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .PCWrite(PCWrite), .hzdetect(hzdetect), .PCSrc(PCSrc),
        .Branch_Address(Branch_Address), .flush(flush),
        .ctrl_out(ctrl_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .pc4_out(pc4_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] na;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        exrw;
        logic [4:0]  exrd;
        logic        e_pcw;
        logic        e_pcsrc;
        logic [31:0] e_ba;
        logic [7:0]  e_ctrl;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [31:0] na,
        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
        input logic exrw, input logic [4:0] exrd,
        input logic e_pcw, input logic e_pcsrc, input logic [31:0] e_ba,
        input logic [7:0] e_ctrl, input logic [31:0] e_rs, input logic [31:0] e_rt);
        vec_t v;
        v.instr = instr; v.na = na; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.exrw = exrw; v.exrd = exrd; v.e_pcw = e_pcw; v.e_pcsrc = e_pcsrc;
        v.e_ba = e_ba; v.e_ctrl = e_ctrl; v.e_rs = e_rs; v.e_rt = e_rt;
        return v;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] na, input logic wbe,
                         input logic [4:0] wba, input logic [31:0] wbd,
                         input logic exrw, input logic [4:0] exrd);
        Instruction = instr; Next_Address = na;
        wb_we = wbe; wb_addr = wba; wb_data = wbd;
        exmem_regwrite = exrw; exmem_rd = exrd;
    endtask

    localparam logic [31:0] NOP = 32'hFC00_0000;

    vec_t tv[17];

    initial begin
        logic [31:0] ins, exp_imm;
        string tag;

        tv[0]  = mk(NOP,                           32'h4,  1, 5'd5,  32'hAA,   0, 5'd0, 1, 0, 32'h4,     8'h00, 32'h0,    32'h0);
        tv[1]  = mk(r_ins(5, 5, 3),                32'h8,  0, 5'd0,  32'h0,    0, 5'd0, 1, 0, 32'h6088,  8'hA1, 32'hAA,   32'hAA);
        tv[2]  = mk(i_ins(6'h08, 7, 8, 16'd5),     32'hC,  1, 5'd7,  32'h1234, 0, 5'd0, 1, 0, 32'h20,    8'h11, 32'h1234, 32'h0);
        tv[3]  = mk(r_ins(0, 7, 9),                32'h10, 1, 5'd0,  32'hDEAD, 0, 5'd0, 1, 0, 32'h12090, 8'hA1, 32'h0,    32'h1234);
        tv[4]  = mk(i_ins(6'h23, 1, 2, 16'd0),     32'h14, 0, 5'd0,  32'h0,    0, 5'd0, 1, 0, 32'h14,    8'h17, 32'h0,    32'h0);
        tv[5]  = mk(r_ins(2, 2, 4),                32'h18, 0, 5'd0,  32'h0,    0, 5'd0, 0, 0, 32'h8098,  8'h00, 32'h0,    32'h0);
        tv[6]  = mk(r_ins(2, 2, 4),                32'h18, 0, 5'd0,  32'h0,    0, 5'd0, 1, 0, 32'h8098,  8'hA1, 32'h0,    32'h0);
        tv[7]  = mk(NOP,                           32'h100,1, 5'd1,  32'h55,   0, 5'd0, 1, 0, 32'h100,   8'h00, 32'h0,    32'h0);
        tv[8]  = mk(i_ins(6'h04, 1, 1, 16'd4),     32'h100,0, 5'd0,  32'h0,    0, 5'd0, 1, 1, 32'h110,   8'h00, 32'h55,   32'h55);
        tv[9]  = mk(i_ins(6'h05, 1, 6, 16'hFFFF),  32'h100,0, 5'd0,  32'h0,    0, 5'd0, 1, 1, 32'hFC,    8'h00, 32'h55,   32'h0);
        tv[10] = mk(i_ins(6'h05, 1, 1, 16'hFFFF),  32'h100,0, 5'd0,  32'h0,    0, 5'd0, 1, 0, 32'hFC,    8'h00, 32'h55,   32'h55);
        tv[11] = mk({6'h02, 26'h40},               32'h8000_0004, 0, 5'd0, 32'h0, 0, 5'd0, 1, 1, 32'h8000_0100, 8'h00, 32'h0, 32'h0);
        tv[12] = mk(i_ins(6'h04, 9, 0, 16'd2),     32'h200,0, 5'd0,  32'h0,    1, 5'd9, 0, 0, 32'h208,   8'h00, 32'h0,    32'h0);
        tv[13] = mk(i_ins(6'h04, 9, 0, 16'd2),     32'h200,0, 5'd0,  32'h0,    0, 5'd9, 1, 1, 32'h208,   8'h00, 32'h0,    32'h0);
        tv[14] = mk(i_ins(6'h08, 0, 10, 16'd1),    32'h300,0, 5'd0,  32'h0,    0, 5'd0, 1, 0, 32'h304,   8'h11, 32'h0,    32'h0);
        tv[15] = mk(i_ins(6'h05, 10, 0, 16'd3),    32'h300,0, 5'd0,  32'h0,    0, 5'd0, 0, 0, 32'h30C,   8'h00, 32'h0,    32'h0);
        tv[16] = mk(i_ins(6'h05, 10, 0, 16'd3),    32'h300,1, 5'd10, 32'h1,    0, 5'd0, 1, 1, 32'h30C,   8'h00, 32'h1,    32'h0);

        // reset
        rst = 1'b0;
        drive(NOP, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
        #12;
        chk("reset ctrl_out", {24'h0, ctrl_out}, 32'h0);
        chk("reset pc4_out", pc4_out, 32'h0);
        chk("reset rs_data_out", rs_data_out, 32'h0);
        chk("reset rd_out", {27'h0, rd_out}, 32'h0);
        chk("reset PCWrite", {31'h0, PCWrite}, 32'h1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].instr, tv[i].na, tv[i].wbe, tv[i].wba, tv[i].wbd, tv[i].exrw, tv[i].exrd);
            #3;
            tag = $sformatf("v%0d", i);
            chk({tag, " PCWrite"},  {31'h0, PCWrite},  {31'h0, tv[i].e_pcw});
            chk({tag, " hzdetect"}, {31'h0, hzdetect}, {31'h0, ~tv[i].e_pcw});
            chk({tag, " PCSrc"},    {31'h0, PCSrc},    {31'h0, tv[i].e_pcsrc});
            chk({tag, " flush"},    {31'h0, flush},    {31'h0, tv[i].e_pcsrc});
            chk({tag, " Branch_Address"}, Branch_Address, tv[i].e_ba);
            @(posedge clk); #1;
            ins = tv[i].instr;
            exp_imm = {{16{ins[15]}}, ins[15:0]};
            chk({tag, " ctrl_out"},    {24'h0, ctrl_out}, {24'h0, tv[i].e_ctrl});
            chk({tag, " rs_data_out"}, rs_data_out, tv[i].e_rs);
            chk({tag, " rt_data_out"}, rt_data_out, tv[i].e_rt);
            chk({tag, " rs_out"},  {27'h0, rs_out}, {27'h0, ins[25:21]});
            chk({tag, " rt_out"},  {27'h0, rt_out}, {27'h0, ins[20:16]});
            chk({tag, " rd_out"},  {27'h0, rd_out}, {27'h0, ins[15:11]});
            chk({tag, " imm_out"}, imm_out, exp_imm);
            chk({tag, " pc4_out"}, pc4_out, tv[i].na);
        end

        // Reset asserted mid-stall: the lw bubble state must vanish at once.
        drive(i_ins(6'h23, 1, 2, 16'd0), 32'h400, 0, 5'd0, 32'h0, 0, 5'd0);
        @(posedge clk); #1;
        drive(r_ins(2, 2, 4), 32'h404, 0, 5'd0, 32'h0, 0, 5'd0);
        #2;
        chk("pre-reset stall PCWrite", {31'h0, PCWrite}, 32'h0);
        rst = 1'b0;
        #1;
        chk("async reset ctrl_out", {24'h0, ctrl_out}, 32'h0);
        chk("async reset pc4_out", pc4_out, 32'h0);
        chk("async reset rt_out", {27'h0, rt_out}, 32'h0);
        chk("async reset PCWrite", {31'h0, PCWrite}, 32'h1);
        chk("async reset hzdetect", {31'h0, hzdetect}, 32'h0);
        @(posedge clk); #1;
        chk("held reset ctrl_out", {24'h0, ctrl_out}, 32'h0);
        rst = 1'b1;
        // r5 held 0xAA before reset; the register file must now read zero.
        drive(r_ins(5, 5, 3), 32'h408, 0, 5'd0, 32'h0, 0, 5'd0);
        @(posedge clk); #1;
        chk("post-reset ctrl_out", {24'h0, ctrl_out}, 32'hA1);
        chk("post-reset r5 cleared", rs_data_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 32-bit five-stage pipeline; consumes the IF/ID pair (next address, instruction).
- Holds the 32x32 register file with write-back bypass, decodes control, and resolves branches/jumps in ID.
- Detects load-use and branch-operand hazards and drives PCWrite/hzdetect/flush back to IF.
- Registers all results into the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, register count (r0 hardwired zero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- Next_Address  in  32  PC+4 from IF/ID
- Instruction  in  32  instruction from IF/ID
- wb_we  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back data
- exmem_regwrite  in  1  MEM-stage instruction writes a register
- exmem_rd  in  5  MEM-stage destination
- PCWrite  out  1  1 = PC may update
- hzdetect  out  1  1 = hold IF/ID
- PCSrc  out  1  1 = IF takes Branch_Address
- Branch_Address  out  32  branch/jump target
- flush  out  1  clear IF/ID next edge
- ctrl_out  out  8  ID/EX control: [0] reg_write, [1] mem_to_reg, [2] mem_read, [3] mem_write, [4] alu_src, [5] reg_dst, [7:6] alu_op (00 add, 01 sub, 10 funct)
- rs_data_out, rt_data_out  out  32  operands
- imm_out  out  32  sign-extended imm16
- rs_out, rt_out, rd_out  out  5  register fields
- pc4_out  out  32  registered Next_Address

Behaviour:
- Decode (opcode = Instruction[31:26]), ctrl bits as {alu_op, reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write}:
  - R 0x00: 10_1_0_0_0_0_1
  - lw 0x23: 00_0_1_0_1_1_1
  - sw 0x2B: 00_0_1_1_0_0_0
  - addi 0x08: 00_0_1_0_0_0_1
  - beq 0x04, bne 0x05, j 0x02: all zero
  - Any other opcode: all zero (NOP).
- Register file:
  - Write on rising clk when wb_we and wb_addr != 0.
  - Reads are combinational; r0 always reads 0.
  - Bypass: if wb_we, wb_addr != 0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Branch unit:
  - Taken = (beq and rs==rt) or (bne and rs!=rt), using bypassed read data.
  - Branch target = Next_Address + (sext(imm16) << 2), 32-bit wrap.
  - j is always taken; target = {Next_Address[31:28], Instruction[25:0], 2'b00}.
  - Branch_Address always shows the computed target.
  - PCSrc = flush = taken AND NOT stall.
- Hazard (stall) is asserted when any of:
  - (a) ID/EX holds mem_read and its rt_out != 0 equals the current rs, or equals the current rt for R/sw/beq/bne.
  - (b) The current instruction is beq/bne and the ID/EX reg_write destination (rd_out if reg_dst, else rt_out), or exmem_rd when exmem_regwrite, is nonzero and matches rs or rt.
- During stall:
  - PCWrite = 0, hzdetect = 1, PCSrc = 0, flush = 0.
  - ID/EX loads a bubble: ctrl_out = 0, other fields don't-care but still loaded.
- Otherwise PCWrite = 1, hzdetect = 0.
- ID/EX register:
  - Updates every rising edge; no enable.
  - Latency of 1 cycle from IF/ID inputs to the *_out ports.
- Reset (rst = 0, async):
  - All ID/EX outputs = 0; all 31 registers = 0.
  - Combinational outputs follow the inputs (after reset ID/EX is empty, so no stall is possible).
  - Reset mid-stall clears the bubble state immediately.
- Simultaneous events:
  - Stall masks a taken branch; the branch re-evaluates next cycle.
  - WB write to a register also being read by a branch resolves through the bypass, with no stall.

Test Plan:
- Reset, then wb writes r5=0x0000_00AA; next cycle Instruction=add r3,r5,r5 -> after one edge rs_data_out=rt_data_out=0xAA, ctrl_out=0xA1, rd_out=3.
- Same-cycle bypass: wb_we=1 wb_addr=7 wb_data=0x1234, Instruction reads r7 -> rs_data_out=0x1234 at next edge. Write to r0 -> r0 still reads 0.
- Load-use: lw r2,0(r1) then add r4,r2,r2 -> one cycle with PCWrite=0, hzdetect=1, ctrl_out=0 bubble; the add issues the following cycle.
- beq r1,r1,+4 with Next_Address=0x100 -> PCSrc=1, flush=1, Branch_Address=0x110. With r1!=r6, bne r1,r6,-1 -> Branch_Address=0x0FC.
- j 0x0000040 with Next_Address=0x8000_0004 -> Branch_Address=0x8000_0100, PCSrc=1.
- beq using r9 while exmem_regwrite=1, exmem_rd=9 -> stall, PCSrc=0. Deassert -> branch taken. Assert rst mid-stall -> all outputs 0 asynchronously.
